// File: rtl/sipo_deser.sv
// MSB-first serial-to-parallel receiver with a one-word valid/ready output buffer and overrun flag.
// Define SIPO_PARITY_EN to expect a trailing even-parity bit per frame and report parity_err.
module sipo_deser #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         si,
  input  logic         si_valid,
  input  logic         start,
  output logic [n-1:0] dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         overrun,
  output logic         parity_err,
  output logic         busy
);

  localparam int CW = $clog2(n + 1);
  localparam logic [CW-1:0] LAST = CW'(n - 1);

`ifdef SIPO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

  state_t         r_state, w_state_nxt;
  logic [n-1:0]   r_shift, w_shift_nxt;
  logic [CW-1:0]  r_cnt, w_cnt_nxt;
  logic [n-1:0]   w_word, w_cpl_word;
  logic           w_cpl, w_free;
  logic [n-1:0]   r_dout;
  logic           r_dv, r_ovr;
`ifdef SIPO_PARITY_EN
  logic           w_cpl_perr, r_perr;
`endif

  assign w_word = {r_shift[n-2:0], si};
  // The buffer can take a new word if empty or being drained on this very edge.
  assign w_free = !r_dv || dout_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_cpl       = 1'b0;
    w_cpl_word  = w_word;
`ifdef SIPO_PARITY_EN
    w_cpl_perr  = 1'b0;
`endif
    if (si_valid && start) begin
      w_shift_nxt = w_word;
      w_cnt_nxt   = CW'(1);
      w_state_nxt = SHIFT;
    end else if (si_valid) begin
      case (r_state)
        SHIFT: begin
          w_shift_nxt = w_word;
          if (r_cnt == LAST) begin
`ifdef SIPO_PARITY_EN
            w_cnt_nxt   = r_cnt + 1'b1;
            w_state_nxt = PARITY;
`else
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
            w_cpl       = 1'b1;
            w_cpl_word  = w_word;
`endif
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
`ifdef SIPO_PARITY_EN
        PARITY: begin
          w_cpl       = 1'b1;
          w_cpl_word  = r_shift;
          w_cpl_perr  = (^r_shift) ^ si;
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_dout  <= '0;
      r_dv    <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ovr   <= w_cpl && !w_free;
      if (w_cpl && w_free) begin
        r_dout <= w_cpl_word;
        r_dv   <= 1'b1;
      end else if (r_dv && dout_ready) begin
        r_dv   <= 1'b0;
      end
    end
  end

`ifdef SIPO_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                r_perr <= 1'b0;
    else if (w_cpl && w_free) r_perr <= w_cpl_perr;
  end
  assign parity_err = r_perr;
`else
  assign parity_err = 1'b0;
`endif

  assign dout       = r_dout;
  assign dout_valid = r_dv;
  assign overrun    = r_ovr;
  assign busy       = (r_state != IDLE);

endmodule
